// File: rtl/instruction_fetch.sv
// Fetch stage: owns the program counter, issues word reads to instruction
// memory and holds the returned instruction in the IR until execute accepts it.
// Execute can redirect fetch after a taken branch, or halt it permanently.
module instruction_fetch #(
  parameter int                ADDR_W   = 16,
  parameter int                DATA_W   = 16,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clock,
  input  logic              reset,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_ack,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              ir_valid,
  input  logic              ir_ready,
  output logic [DATA_W-1:0] ir_data,
  output logic [ADDR_W-1:0] ir_pc,
  input  logic              redirect,
  input  logic [ADDR_W-1:0] redirect_pc,
  input  logic              halt,
  output logic              halted
);

  typedef enum logic [2:0] {
    BOOT    = 3'd0,
    REQ     = 3'd1,
    FULL    = 3'd2,
    DISCARD = 3'd3,
    HALTED  = 3'd4
  } state_t;

  localparam logic [ADDR_W-1:0] PC_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};

  state_t            state;
  logic [ADDR_W-1:0] pc;
  logic [ADDR_W-1:0] pending_pc;
  logic              halt_pending;
  logic [ADDR_W-1:0] pc_inc;
  logic [ADDR_W-1:0] discard_target;

  // Sequential PC wraps naturally at the top of the address space.
  assign pc_inc = pc + PC_ONE;

  // A redirect arriving in the same cycle as the dropped ack is newer than the
  // stored target, so it wins.
  assign discard_target = redirect ? redirect_pc : pending_pc;

  // Fetch state machine; all outputs are registered.
  // Priority in every state is halt, then redirect, then normal flow.
  // A memory request, once raised, keeps mem_req and mem_addr fixed until the
  // ack, so flushes during an outstanding read go through DISCARD.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state        <= BOOT;
      pc           <= RESET_PC;
      pending_pc   <= RESET_PC;
      halt_pending <= 1'b0;
      mem_req      <= 1'b0;
      mem_addr     <= RESET_PC;
      ir_valid     <= 1'b0;
      ir_data      <= '0;
      ir_pc        <= '0;
      halted       <= 1'b0;
    end else begin
      case (state)
        BOOT: begin
          if (halt) begin
            halted <= 1'b1;
            state  <= HALTED;
          end else if (redirect) begin
            pc       <= redirect_pc;
            mem_addr <= redirect_pc;
            mem_req  <= 1'b1;
            state    <= REQ;
          end else begin
            mem_addr <= pc;
            mem_req  <= 1'b1;
            state    <= REQ;
          end
        end

        REQ: begin
          if (halt) begin
            if (mem_ack) begin
              mem_req <= 1'b0;
              halted  <= 1'b1;
              state   <= HALTED;
            end else begin
              halt_pending <= 1'b1;
              state        <= DISCARD;
            end
          end else if (redirect) begin
            if (mem_ack) begin
              pc       <= redirect_pc;
              mem_addr <= redirect_pc;
            end else begin
              pending_pc <= redirect_pc;
              state      <= DISCARD;
            end
          end else if (mem_ack) begin
            ir_data  <= mem_rdata;
            ir_pc    <= pc;
            pc       <= pc_inc;
            ir_valid <= 1'b1;
            mem_req  <= 1'b0;
            state    <= FULL;
          end
        end

        FULL: begin
          if (halt) begin
            ir_valid <= 1'b0;
            halted   <= 1'b1;
            state    <= HALTED;
          end else if (redirect) begin
            ir_valid <= 1'b0;
            pc       <= redirect_pc;
            mem_addr <= redirect_pc;
            mem_req  <= 1'b1;
            state    <= REQ;
          end else if (ir_ready) begin
            ir_valid <= 1'b0;
            mem_addr <= pc;
            mem_req  <= 1'b1;
            state    <= REQ;
          end
        end

        DISCARD: begin
          if (mem_ack) begin
            if (halt || halt_pending) begin
              halt_pending <= 1'b0;
              mem_req      <= 1'b0;
              halted       <= 1'b1;
              state        <= HALTED;
            end else begin
              pc       <= discard_target;
              mem_addr <= discard_target;
              state    <= REQ;
            end
          end else if (halt) begin
            halt_pending <= 1'b1;
          end else if (redirect) begin
            pending_pc <= redirect_pc;
          end
        end

        HALTED: begin
          mem_req  <= 1'b0;
          ir_valid <= 1'b0;
          halted   <= 1'b1;
        end

        default: begin
          mem_req  <= 1'b0;
          ir_valid <= 1'b0;
          state    <= BOOT;
        end
      endcase
    end
  end

endmodule
